// File: rtl/ice_board_pkg.sv
// Shared board-level definitions for the CPU clock source and its display path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ice_board_pkg;

  // CPU clock generator states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } clk_state_e;

  // Width of the exported step counter
  localparam int STEP_W = 16;

endpackage

// File: rtl/key_debouncer.sv
// Key synchroniser and debouncer: accepts a new key level after it has been stable pDebounceCycles cycles.
// Latency: raw edge reaches owStable 2+pDebounceCycles cycles later; owRise is high in the cycle before owStable rises.
// Backpressure: none; owRise is a single-cycle event that the consumer must take or lose.
// Ports: iwClk clock, iwRst async active-high reset, iwKey raw bouncing key,
//        owStable accepted key level, owRise one-cycle press event (accepted 0->1).
module key_debouncer #(
  parameter int unsigned pDebounceCycles = 32'd1000000
) (
  input  logic iwClk,
  input  logic iwRst,
  input  logic iwKey,
  output logic owStable,
  output logic owRise
);

  localparam int CW = (pDebounceCycles > 1) ? $clog2(pDebounceCycles) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(pDebounceCycles - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    // Counter only runs while the synchronised level disagrees with the accepted one.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= iwKey;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign owStable = stable_q;
  // Taken from the next-state so a consumer can register the event on the same edge the level is accepted.
  assign owRise   = stable_d & ~stable_q;

endmodule

// File: rtl/key_step_clock.sv
// CPU clock source: free-running clock of pRunFactor board cycles, or one period per debounced key press.
// Latency: run rise -> owCpuClk rise 4 cycles; accepted press -> owCpuClk rise 2 cycles.
// Backpressure: one-deep pending press; further presses during a pending period are dropped.
// Ports: iwClk 100 MHz board clock, iwRst async active-high reset, iwKey raw key, iwRun 1=free-run/0=step,
//        owCpuClk generated clock, owBusy period in progress, owSteps count of owCpuClk rising edges (wraps).
// Build option: define KEY_STEP_CLOCK_REPEAT_EN for auto-repeat every pRepeatCycles while the key is held.
module key_step_clock
  import ice_board_pkg::*;
#(
  parameter int unsigned pDebounceCycles = 32'd1000000,
  parameter int unsigned pRunFactor      = 32'd4,
  parameter int unsigned pRepeatCycles   = 32'd25000000
) (
  input  logic              iwClk,
  input  logic              iwRst,
  input  logic              iwKey,
  input  logic              iwRun,
  output logic              owCpuClk,
  output logic              owBusy,
  output logic [STEP_W-1:0] owSteps
);

  localparam int unsigned HALF = pRunFactor / 2;
  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(HALF - 1);

`ifdef KEY_STEP_CLOCK_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif
  localparam int RW = (pRepeatCycles > 1) ? $clog2(pRepeatCycles) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(pRepeatCycles - 1);

  logic key_stable, key_rise;

  key_debouncer #(
    .pDebounceCycles(pDebounceCycles)
  ) u_key (
    .iwClk   (iwClk),
    .iwRst   (iwRst),
    .iwKey   (iwKey),
    .owStable(key_stable),
    .owRise  (key_rise)
  );

  logic run_s1_q, run_s2_q;

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
    end else begin
      run_s1_q <= iwRun;
      run_s2_q <= run_s1_q;
    end
  end

  // Auto-repeat: while the accepted level stays high, fire another press every pRepeatCycles.
  // With the option off REPEAT_EN is a constant 0 and the counter folds away.
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_fire;

  always_comb begin
    rpt_cnt_d = '0;
    rpt_fire  = 1'b0;
    if (REPEAT_EN && key_stable) begin
      if (rpt_cnt_q == RPT_LAST) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) rpt_cnt_q <= '0;
    else       rpt_cnt_q <= rpt_cnt_d;
  end

  logic press;
  assign press = key_rise | rpt_fire;

  clk_state_e        state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              pending_q, pending_d;
  logic              cpu_clk_q, cpu_clk_d;
  logic              busy_q, busy_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              want, start;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    start     = 1'b0;
    // Mode is only consulted here, at IDLE exit and at the end of LOW, so phases are never cut short.
    want      = run_s2_q | pending_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (want) begin
          state_d = ST_HIGH;
          start   = 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_q == PHASE_LAST) begin
          state_d = ST_LOW;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_LOW: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          if (want) begin
            state_d = ST_HIGH;
            start   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase

    // A press landing on the cycle the flag is consumed is kept for the following period.
    pending_d = pending_q;
    if (run_s2_q)   pending_d = 1'b0;
    else if (press) pending_d = 1'b1;
    else if (start) pending_d = 1'b0;

    // Outputs are registered from the current state; owSteps counts owCpuClk rising edges.
    cpu_clk_d = (state_q == ST_HIGH);
    busy_d    = (state_q != ST_IDLE);
    steps_d   = steps_q + {{(STEP_W-1){1'b0}}, cpu_clk_d & ~cpu_clk_q};
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      pending_q <= 1'b0;
      cpu_clk_q <= 1'b0;
      busy_q    <= 1'b0;
      steps_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      cpu_clk_q <= cpu_clk_d;
      busy_q    <= busy_d;
      steps_q   <= steps_d;
    end
  end

  assign owCpuClk = cpu_clk_q;
  assign owBusy   = busy_q;
  assign owSteps  = steps_q;

endmodule

// File: tb/tb_key_step_clock.sv
// Bench for key_step_clock: instance A (debounce 4, run factor 4), instance B (debounce 4, run factor 16).
// Latency: n/a.
// Backpressure: n/a.
module tb_key_step_clock;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_a, run_a, cpu_a, busy_a;
  logic [15:0] steps_a;
  logic        key_b, run_b, cpu_b, busy_b;
  logic [15:0] steps_b;

  int checks = 0;
  int errors = 0;
  int model_steps = 0;

  key_step_clock #(.pDebounceCycles(4), .pRunFactor(4), .pRepeatCycles(64)) u_dut_a (
    .iwClk(clk), .iwRst(rst), .iwKey(key_a), .iwRun(run_a),
    .owCpuClk(cpu_a), .owBusy(busy_a), .owSteps(steps_a)
  );

  key_step_clock #(.pDebounceCycles(4), .pRunFactor(16), .pRepeatCycles(64)) u_dut_b (
    .iwClk(clk), .iwRst(rst), .iwKey(key_b), .iwRun(run_b),
    .owCpuClk(cpu_b), .owBusy(busy_b), .owSteps(steps_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a run burst of t cycles started from idle gets one period per decision point
  // (first at 3 cycles, then every 4) that still sees the synchronised run level.
  function automatic int run_steps(input int t);
    return (t - 1) / 4 + 1;
  endfunction

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_a && n < 200) begin
      tick(1);
      n++;
    end
    chk(nm, int'(busy_a), 0);
  endtask

  task automatic wait_rise(input string nm);
    int n = 0;
    while (!cpu_a && n < 50) begin
      tick(1);
      n++;
    end
    chk(nm, int'(cpu_a), 1);
  endtask

  // Waveform monitor for instance A: every high phase is 2 samples, every low gap at least 2.
  int hi_len = 0, lo_len = 0, hi_total = 0;
  bit have_low = 1'b0, prev_cpu = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hi_len   <= 0;
      lo_len   <= 0;
      have_low <= 1'b0;
      prev_cpu <= 1'b0;
    end else begin
      if (cpu_a) begin
        hi_total <= hi_total + 1;
        if (!prev_cpu) begin
          hi_len <= 1;
          if (have_low) chk("low_gap", int'(lo_len >= 2), 1);
        end else begin
          hi_len <= hi_len + 1;
        end
      end else if (prev_cpu) begin
        chk("high_width", hi_len, 2);
        lo_len   <= 1;
        have_low <= 1'b1;
      end else begin
        lo_len <= lo_len + 1;
      end
      prev_cpu <= cpu_a;
    end
  end

  // Instance B monitor: rising edges and spacing between them.
  int cyc = 0, rise_b = 0, last_rise_b = 0;
  bit prev_b = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rise_b <= 0;
      prev_b <= 1'b0;
    end else begin
      if (cpu_b && !prev_b) begin
        if (rise_b > 0) chk("b_back_to_back", cyc - last_rise_b, 16);
        last_rise_b <= cyc;
        rise_b      <= rise_b + 1;
      end
      prev_b <= cpu_b;
    end
  end

  typedef struct {
    int run_len;
    int exp_steps;
    int exp_hi;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s0, h0, mism, busy_low, first_hi, hi_cnt, op, t;

    vecs[0] = '{1, 1, 2};
    vecs[1] = '{4, 1, 2};
    vecs[2] = '{5, 2, 4};
    vecs[3] = '{8, 2, 4};
    vecs[4] = '{9, 3, 6};
    vecs[5] = '{22, 6, 12};

    // Reset with key and run both asserted.
    rst = 1'b1; key_a = 1'b1; run_a = 1'b1; key_b = 1'b0; run_b = 1'b0;
    tick(1);
    chk("rst_cpu", int'(cpu_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_steps", int'(steps_a), 0);
    tick(2);
    chk("rst_cpu_held", int'(cpu_a), 0);
    rst = 1'b0;
    tick(3);
    chk("rst_rise_not_early", int'(cpu_a), 0);
    tick(1);
    chk("rst_first_rise", int'(cpu_a), 1);

    // Free-run: 40 samples of 1,1,0,0 with busy held.
    mism = 0; busy_low = 0;
    for (int i = 0; i < 40; i++) begin
      if (cpu_a !== ((i % 4) < 2)) mism++;
      if (!busy_a) busy_low++;
      if (i < 39) tick(1);
    end
    chk("free_run_pattern", mism, 0);
    chk("free_run_busy", busy_low, 0);
    chk("free_run_steps", int'(steps_a), 10);
    run_a = 1'b0; key_a = 1'b0;
    model_steps = run_steps(43);
    tick(20);
    wait_idle("free_run_idle");
    chk("free_run_total", int'(steps_a), model_steps);

    // Table: run bursts of given length from idle.
    foreach (vecs[k]) begin
      s0 = int'(steps_a); h0 = hi_total;
      run_a = 1'b1;
      tick(vecs[k].run_len);
      run_a = 1'b0;
      tick(20);
      wait_idle("tbl_idle");
      chk("tbl_steps", int'(steps_a) - s0, vecs[k].exp_steps);
      chk("tbl_high_cycles", hi_total - h0, vecs[k].exp_hi);
      model_steps += vecs[k].exp_steps;
    end

    // Single step: key high 10 cycles; clock rises 8 cycles after the raw rise.
    first_hi = -1; hi_cnt = 0;
    key_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i == 9) key_a = 1'b0;
      if (cpu_a) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
      end
    end
    tick(10);
    model_steps += 1;
    chk("step_latency", first_hi, 7);
    chk("step_high_cnt", hi_cnt, 2);
    chk("step_busy", int'(busy_a), 0);
    chk("step_steps", int'(steps_a), model_steps);

    // Bounce: key toggles every 2 cycles; never stable long enough.
    h0 = hi_total;
    for (int i = 0; i < 30; i++) begin
      key_a = ((i / 2) % 2) == 0;
      tick(1);
    end
    key_a = 1'b0;
    tick(20);
    chk("bounce_steps", int'(steps_a), model_steps);
    chk("bounce_high", hi_total - h0, 0);

    // Mode change: drop run during the first HIGH; the period completes, then idle.
    s0 = int'(steps_a); h0 = hi_total;
    run_a = 1'b1;
    wait_rise("mode_rise");
    run_a = 1'b0;
    tick(20);
    wait_idle("mode_idle");
    chk("mode_steps", int'(steps_a) - s0, 1);
    chk("mode_high", hi_total - h0, 2);
    model_steps += 1;

    // Pending on instance B: three clean presses 8 cycles apart during one 16-cycle period.
    for (int p = 0; p < 3; p++) begin
      key_b = 1'b1;
      tick(4);
      key_b = 1'b0;
      tick(4);
    end
    tick(60);
    chk("pend_rises", rise_b, 2);
    chk("pend_steps", int'(steps_b), 2);
    chk("pend_busy", int'(busy_b), 0);

    // Randomized operations against the arithmetic model.
    for (int r = 0; r < 16; r++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        t = int'($urandom_range(1, 30));
        run_a = 1'b1;
        tick(t);
        run_a = 1'b0;
        model_steps += run_steps(t);
      end else if (op == 1) begin
        key_a = 1'b1;
        tick(int'($urandom_range(4, 12)));
        key_a = 1'b0;
        model_steps += 1;
      end else begin
        for (int g = 0; g < 5; g++) begin
          key_a = 1'b1;
          tick(int'($urandom_range(1, 3)));
          key_a = 1'b0;
          tick(int'($urandom_range(1, 3)));
        end
      end
      tick(24);
      wait_idle("rnd_idle");
      chk("rnd_steps", int'(steps_a), model_steps % 65536);
    end

    // Asynchronous reset in the middle of a high phase.
    run_a = 1'b1;
    wait_rise("arst_rise");
    tick(1);
    rst = 1'b1;
    #1;
    chk("arst_cpu", int'(cpu_a), 0);
    chk("arst_busy", int'(busy_a), 0);
    chk("arst_steps", int'(steps_a), 0);
    run_a = 1'b0;
    tick(2);
    rst = 1'b0;
    model_steps = 0;
    tick(6);

    // Wrap: preload the counter near the top, then two steps take it through zero.
    force u_dut_a.steps_q = 16'hFFFE;
    tick(1);
    release u_dut_a.steps_q;
    model_steps = 65534;
    run_a = 1'b1;
    tick(5);
    run_a = 1'b0;
    model_steps += run_steps(5);
    tick(20);
    wait_idle("wrap_idle");
    chk("wrap_steps", int'(steps_a), model_steps % 65536);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
